// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin sharing of one sequential multiplier between NUM_REQ requesters; define MULT_TIMEOUT_EN for a wait watchdog
module mult_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       mult_start,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic                       mult_ready,
  input  logic [2*WIDTH-1:0]         mult_product,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic                       rsp_error,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] ptr, win, id_q;
  logic [WIDTH-1:0] op_a, op_b, win_a, win_b;
  logic found, grant, done, expire;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req_valid[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
  end
  assign win_a = req_a[int'(win)*WIDTH +: WIDTH];
  assign win_b = req_b[int'(win)*WIDTH +: WIDTH];
  // reset_n gates the grant so req_ready is low while reset is held
  assign grant = reset_n && state == IDLE && found && mult_ready;
  assign req_ready = grant ? NUM_REQ'(1) << win : '0;
  assign done = state == WAIT_DONE && mult_ready;
  assign mult_start = state == ISSUE;
  assign mult_a = op_a;
  assign mult_b = op_b;
  assign rsp_valid = state == RESPOND;
  assign rsp_id = id_q;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = !grant ? IDLE : (win_a == '0 || win_b == '0) ? RESPOND : ISSUE;
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = expire ? RESPOND : mult_ready ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: state_n = (done || expire) ? RESPOND : WAIT_DONE;
      RESPOND:   state_n = rsp_ready ? IDLE : RESPOND;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      id_q <= '0;
      rsp_product <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        op_a <= win_a;
        op_b <= win_b;
        id_q <= win;
        rsp_product <= '0;
      end
      if (done) rsp_product <= mult_product;
    end
`ifdef MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd;
  logic waiting;
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
  // a completion in the same cycle as expiry wins
  assign expire = waiting && !done && wd == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wd <= '0;
      rsp_error <= 1'b0;
    end else begin
      wd <= waiting ? wd + 1'b1 : '0;
      rsp_error <= grant ? 1'b0 : expire ? 1'b1 : rsp_error;
    end
`else
  assign expire = 1'b0;
  assign rsp_error = 1'b0;
`endif
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed checks of arbitration, bypass, backpressure and reset with a behavioural multiplier
module tb_mult_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0, reset_n = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] req_ready;
  logic mult_start, mult_ready = 1'b1;
  logic [W-1:0] mult_a, mult_b, ma, mb;
  logic [2*W-1:0] mult_product = '0, rsp_product;
  logic rsp_valid, rsp_ready = 1'b0, rsp_error, busy, hang = 1'b0;
  logic [1:0] rsp_id;
  int vectors = 0, miscompares = 0, start_cnt = 0, lat = 4;

  mult_scheduler #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_ready(mult_ready), .mult_product(mult_product), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_error(rsp_error), .busy(busy));

  always #5 clk = ~clk;

  // behavioural multiplier: drops ready after start, returns a*b lat cycles later
  initial forever begin
    @(negedge clk);
    if (mult_start) begin
      ma = mult_a;
      mb = mult_b;
      start_cnt++;
      mult_ready = 1'b0;
      repeat (lat) @(negedge clk);
      while (hang) @(negedge clk);
      mult_product = 16'(ma) * 16'(mb);
      mult_ready = 1'b1;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (!rsp_valid && n < 200);
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset;
    int n;
    n = 0;
    while (!mult_ready && n < 100) begin
      tick;
      n++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    #1;
    req_valid = '1;
    req_a = '1;
    req_b = '1;
    reset_n = 1'b0;
    tick;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    vectors++; if (mult_start !== 1'b0) begin miscompares++; $display("FAIL reset_mult_start: got %b want 0", mult_start); end
    vectors++; if (mult_a !== 8'd0 || mult_b !== 8'd0) begin miscompares++; $display("FAIL reset_operands: got %0d/%0d want 0/0", mult_a, mult_b); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_id !== 2'd0 || rsp_product !== 16'd0) begin miscompares++; $display("FAIL reset_rsp: got id %0d prod %0d want 0/0", rsp_id, rsp_product); end
    vectors++; if (rsp_error !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got err %b busy %b want 0/0", rsp_error, busy); end
    req_valid = '0;
    reset_n = 1'b1;
    tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_single;
    int n;
    do_reset;
    req_a[0+:W] = 8'd13;
    req_b[0+:W] = 8'd11;
    req_valid = 4'b0001;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    vectors++; if (mult_start !== 1'b1) begin miscompares++; $display("FAIL single_start: got %b want 1", mult_start); end
    vectors++; if (mult_a !== 8'd13 || mult_b !== 8'd11) begin miscompares++; $display("FAIL single_operands: got %0d/%0d want 13/11", mult_a, mult_b); end
    tick;
    vectors++; if (mult_start !== 1'b0) begin miscompares++; $display("FAIL single_start_pulse: got %b want 0", mult_start); end
    vectors++; if (mult_a !== 8'd13 || mult_b !== 8'd11) begin miscompares++; $display("FAIL single_hold: got %0d/%0d want 13/11", mult_a, mult_b); end
    wait_rsp(n);
    vectors++; if (n !== 4 || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency: got %0d cycles after wait start, valid %b, want 4 and 1", n, rsp_valid); end
    vectors++; if (rsp_id !== 2'd0 || rsp_product !== 16'd143) begin miscompares++; $display("FAIL single_rsp: got id %0d prod %0d want 0/143", rsp_id, rsp_product); end
    vectors++; if (rsp_error !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b want 0", rsp_error); end
    handshake;
    vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_done: got busy %b valid %b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_contention;
    int n, s0;
    logic [3:0] exp;
    do_reset;
    for (int i = 0; i < N; i++) begin
      req_a[i*W+:W] = 8'(i + 2);
      req_b[i*W+:W] = 8'd3;
    end
    s0 = start_cnt;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        tick;
        n++;
      end
      exp = 4'b0001 << (j % 4);
      vectors++; if (req_ready !== exp) begin miscompares++; $display("FAIL contention_grant%0d: got %b want %b", j, req_ready, exp); end
      wait_rsp(n);
      vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(j % 4)) begin miscompares++; $display("FAIL contention_id%0d: got valid %b id %0d want 1/%0d", j, rsp_valid, rsp_id, j % 4); end
      vectors++; if (rsp_product !== 16'((j % 4 + 2) * 3)) begin miscompares++; $display("FAIL contention_prod%0d: got %0d want %0d", j, rsp_product, (j % 4 + 2) * 3); end
    end
    req_valid = '0;
    tick;
    rsp_ready = 1'b0;
    vectors++; if (start_cnt - s0 !== 5) begin miscompares++; $display("FAIL contention_starts: got %0d want 5", start_cnt - s0); end
  endtask

  task automatic test_bypass;
    int s0;
    do_reset;
    req_a[2*W+:W] = 8'd200;
    req_b[2*W+:W] = 8'd0;
    req_valid = 4'b0100;
    s0 = start_cnt;
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL bypass_grant: got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bypass_latency: got valid %b want 1", rsp_valid); end
    vectors++; if (rsp_id !== 2'd2 || rsp_product !== 16'd0) begin miscompares++; $display("FAIL bypass_rsp: got id %0d prod %0d want 2/0", rsp_id, rsp_product); end
    vectors++; if (mult_start !== 1'b0) begin miscompares++; $display("FAIL bypass_no_start: got %b want 0", mult_start); end
    handshake;
    tick;
    vectors++; if (start_cnt !== s0) begin miscompares++; $display("FAIL bypass_start_cnt: got %0d want %0d", start_cnt, s0); end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset;
    req_a[1*W+:W] = 8'd255;
    req_b[1*W+:W] = 8'd255;
    req_valid = 4'b0010;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    tick;
    wait_rsp(n);
    for (int k = 0; k < 10; k++) begin
      vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin miscompares++; $display("FAIL bp_hold_valid%0d: got valid %b id %0d want 1/1", k, rsp_valid, rsp_id); end
      vectors++; if (rsp_product !== 16'd65025) begin miscompares++; $display("FAIL bp_hold_prod%0d: got %0d want 65025", k, rsp_product); end
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_no_grant%0d: got %b want 0000", k, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_handshake_cycle: got %b want 0000", req_ready); end
    tick;
    rsp_ready = 1'b0;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_regrant: got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    wait_rsp(n);
    vectors++; if (rsp_valid !== 1'b1 || rsp_product !== 16'd65025) begin miscompares++; $display("FAIL bp_second: got valid %b prod %0d want 1/65025", rsp_valid, rsp_product); end
    handshake;
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset;
    lat = 12;
    req_a[0+:W] = 8'd3;
    req_b[0+:W] = 8'd5;
    req_valid = 4'b0001;
    #1;
    tick;
    req_valid = '0;
    tick;
    tick;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
    req_a[3*W+:W] = 8'd7;
    req_b[3*W+:W] = 8'd2;
    req_valid = 4'b1000;
    reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || mult_start !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ctl: got busy %b valid %b start %b want 0/0/0", busy, rsp_valid, mult_start); end
    vectors++; if (mult_a !== 8'd0 || mult_b !== 8'd0) begin miscompares++; $display("FAIL mid_reset_ops: got %0d/%0d want 0/0", mult_a, mult_b); end
    vectors++; if (rsp_product !== 16'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_rsp: got prod %0d id %0d ready %b want 0/0/0000", rsp_product, rsp_id, req_ready); end
    tick;
    reset_n = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_wait_mult_ready: got %b want 0000", req_ready); end
    n = 0;
    while (req_ready == '0 && n < 40) begin
      tick;
      n++;
    end
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL mid_first_grant: got %b want 1000", req_ready); end
    tick;
    req_valid = '0;
    lat = 4;
    wait_rsp(n);
    vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== 16'd14) begin miscompares++; $display("FAIL mid_rsp: got valid %b id %0d prod %0d want 1/3/14", rsp_valid, rsp_id, rsp_product); end
    handshake;
  endtask

`ifdef MULT_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    do_reset;
    hang = 1'b1;
    req_a[0+:W] = 8'd1;
    req_b[0+:W] = 8'd1;
    req_valid = 4'b0001;
    #1;
    tick;
    req_valid = '0;
    wait_rsp(n);
    vectors++; if (rsp_valid !== 1'b1 || n !== 65) begin miscompares++; $display("FAIL timeout_latency: got valid %b after %0d cycles want 1 after 65", rsp_valid, n); end
    vectors++; if (rsp_error !== 1'b1 || rsp_product !== 16'd0) begin miscompares++; $display("FAIL timeout_rsp: got err %b prod %0d want 1/0", rsp_error, rsp_product); end
    handshake;
    req_valid = 4'b0001;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL timeout_no_grant: got %b want 0000", req_ready); end
    req_valid = '0;
    hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_bypass;
    test_backpressure;
    test_reset_mid;
`ifdef MULT_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
